// File: rtl/as_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters.
// Define AS_TX_ARB_WDOG_EN to enable the WAIT-state watchdog abort (err_o).
package as_pack;
    parameter int unsigned uart_width = 8;
endpackage

module as_tx_arb
    import as_pack::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned WDOG_CYC = 2000000
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NREQ-1:0]            req_i,
    input  logic [NREQ*uart_width-1:0] data_i,
    output logic [NREQ-1:0]            gnt_o,
    output logic                       busy_o,
    output logic                       tx_start_o,
    output logic [uart_width-1:0]      tx_data_o,
    input  logic                       tx_rdy_i,
    output logic                       err_o
);
    localparam int unsigned IdxW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || WDOG_CYC == 0) begin : g_bad_param
        $error("as_tx_arb: NREQ must be 2..8 and WDOG_CYC nonzero");
    end

    typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       last_q, last_d;
    logic [IdxW-1:0]       win_q, win_d;
    logic [uart_width-1:0] data_q, data_d;
    logic [IdxW-1:0]       pick;
    logic                  found;
    logic [31:0]           cand;
    logic                  wdog_hit;
    logic [uart_width-1:0] bytes_w [NREQ];

    for (genvar n = 0; n < NREQ; n++) begin : g_bytes
        assign bytes_w[n] = data_i[n*uart_width +: uart_width];
    end

    // Search last+1, last+2, ... with wrap; the first active requester wins.
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = 32'(last_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req_i[cand[IdxW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IdxW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StSend;
                    win_d   = pick;
                    data_d  = bytes_w[pick];
                end
            end
            StSend: begin
                state_d = StWait;
                last_d  = win_q;
            end
            StWait: begin
                if (tx_rdy_i || wdog_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            last_q  <= IdxW'(NREQ - 1);
            win_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            data_q  <= data_d;
        end
    end

`ifdef AS_TX_ARB_WDOG_EN
    localparam int unsigned CntW = $clog2(WDOG_CYC + 1);

    logic [CntW-1:0] wdog_q, wdog_d;
    logic            err_q;

    // wdog_q counts completed WAIT cycles; the limit hits during the last allowed one.
    assign wdog_hit = (wdog_q == CntW'(WDOG_CYC - 1));

    always_comb begin
        wdog_d = wdog_q;
        if (state_q == StSend) begin
            wdog_d = '0;
        end else if (state_q == StWait) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= (state_q == StWait) && !tx_rdy_i && wdog_hit;
        end
    end

    assign err_o = err_q;
`else
    assign wdog_hit = 1'b0;
    assign err_o    = 1'b0;
`endif

    assign busy_o     = (state_q != StIdle);
    assign tx_start_o = (state_q == StSend);
    assign gnt_o      = (state_q == StSend) ? (NREQ'(1) << win_q) : '0;
    assign tx_data_o  = data_q;

endmodule

// File: tb/tb_as_tx_arb.sv
// Self-checking bench for as_tx_arb: transaction-level reference model plus directed scenarios.
// Define AS_TX_ARB_WDOG_EN to exercise the watchdog build (WDOG_CYC = 16).
module tb_as_tx_arb;
    localparam int NREQ = 4;
    localparam int WDOG = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data = '0;
    logic        tx_rdy = 1'b0;
    logic [3:0]  gnt;
    logic        busy, tx_start, err;
    logic [7:0]  tx_data;

    int n_vec = 0;
    int n_err = 0;

    as_tx_arb #(.NREQ(NREQ), .WDOG_CYC(WDOG)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .data_i     (data),
        .gnt_o      (gnt),
        .busy_o     (busy),
        .tx_start_o (tx_start),
        .tx_data_o  (tx_data),
        .tx_rdy_i   (tx_rdy),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is "grant cycle, then busy until rdy (or watchdog)".
    int          m_last, m_win, m_wait;
    bit          m_send, m_busy, m_err;
    logic [7:0]  m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last = NREQ - 1; m_win = 0; m_wait = 0;
            m_send = 0; m_busy = 0; m_err = 0; m_data = '0;
        end else begin
            m_err = 0;
            if (m_send) begin
                m_send = 0; m_last = m_win; m_wait = 0;
            end else if (m_busy) begin
                if (tx_rdy) m_busy = 0;
`ifdef AS_TX_ARB_WDOG_EN
                else begin
                    m_wait++;
                    if (m_wait == WDOG) begin m_busy = 0; m_err = 1; end
                end
`endif
            end else if (req != 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (req[(m_last + k) % NREQ]) begin m_win = (m_last + k) % NREQ; break; end
                end
                m_data = data[m_win*8 +: 8];
                m_send = 1; m_busy = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("gnt", 32'(gnt), m_send ? (32'd1 << m_win) : 32'd0);
        chk("tx_start", 32'(tx_start), 32'(m_send));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("tx_data", 32'(tx_data), 32'(m_data));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_gnt"}, 32'(gnt), 0);
        chk({name, "_busy"}, 32'(busy), 0);
        chk({name, "_start"}, 32'(tx_start), 0);
        chk({name, "_data"}, 32'(tx_data), 0);
        chk({name, "_err"}, 32'(err), 0);
    endtask

    // Asserts reset between edges, checks outputs, releases on the next falling edge.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1 chk_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int order[5];
    int got, cnt, bad;

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("por");
        rst_n = 1'b1;

        // Single request from requester 2
        req = 4'b0100; data = 32'h00A5_0000;
        step();
        chk("single_gnt", 32'(gnt), 32'b0100);
        chk("single_start", 32'(tx_start), 1);
        chk("single_data", 32'(tx_data), 32'hA5);
        req = '0;
        step();
        chk("single_busy", 32'(busy), 1);
        chk("single_gnt_off", 32'(gnt), 0);
        step();
        tx_rdy = 1'b1;
        step();
        tx_rdy = 1'b0;
        chk("single_busy_end", 32'(busy), 0);
        chk("single_data_hold", 32'(tx_data), 32'hA5);

        // Fairness with all four requesting continuously
        do_reset();
        req = 4'b1111; data = 32'h4433_2211; got = 0;
        for (int c = 0; c < 100 && got < 5; c++) begin
            step();
            if (gnt != 0) begin
                for (int n = 0; n < NREQ; n++) if (gnt[n]) order[got] = n;
                got++;
            end
            tx_rdy = busy && !tx_start;
        end
        tx_rdy = 1'b0; req = '0;
        chk("fair_count", 32'(got), 5);
        for (int i = 0; i < 5; i++) chk("fair_order", 32'(order[i]), 32'(i % NREQ));
        step(); step();

        // Late request: 3 arrives while 1 is in flight, 2 already pending
        do_reset();
        req = 4'b0110; data = 32'h0403_0201;
        step();
        chk("late_gnt1", 32'(gnt), 32'b0010);
        req[1] = 1'b0;
        step();
        req[3] = 1'b1;
        step();
        tx_rdy = 1'b1;
        step();
        tx_rdy = 1'b0;
        step();
        chk("late_gnt2", 32'(gnt), 32'b0100);
        chk("late_data2", 32'(tx_data), 32'h03);
        req[2] = 1'b0;
        step();
        tx_rdy = 1'b1;
        step();
        tx_rdy = 1'b0;
        step();
        chk("late_gnt3", 32'(gnt), 32'b1000);
        req = '0;
        step();
        tx_rdy = 1'b1;
        step();
        tx_rdy = 1'b0;

        // Withdrawal: one-cycle pulse on req[1] during WAIT is never granted
        req = 4'b0001;
        step();
        chk("wd_gnt0", 32'(gnt), 32'b0001);
        req = '0;
        step();
        req[1] = 1'b1;
        step();
        req[1] = 1'b0;
        step();
        tx_rdy = 1'b1;
        step();
        tx_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wd_no_gnt", 32'(gnt), 0);
        end

        // Reset mid-WAIT, then requester 3 wins first arbitration after release
        req = 4'b0001;
        step();
        req = '0;
        step(); step();
        #1 rst_n = 1'b0;
        #1 chk_all_zero("midwait");
        req = 4'b1000;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_gnt", 32'(gnt), 32'b1000);
        req = '0;
        step();
        tx_rdy = 1'b1;
        step();
        tx_rdy = 1'b0;

`ifdef AS_TX_ARB_WDOG_EN
        // Watchdog fires after 16 WAIT cycles without rdy
        req = 4'b0001;
        step();
        req = '0; cnt = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            cnt++;
            if (err) break;
        end
        chk("wdog_delay", 32'(cnt), 17);
        chk("wdog_idle", 32'(busy), 0);
        step();
        chk("wdog_once", 32'(err), 0);
        // rdy in the 16th WAIT cycle wins over the limit
        req = 4'b0010;
        step();
        req = '0;
        repeat (16) step();
        chk("wdog_rdy_busy", 32'(busy), 1);
        tx_rdy = 1'b1;
        step();
        tx_rdy = 1'b0;
        chk("wdog_rdy_err", 32'(err), 0);
        chk("wdog_rdy_idle", 32'(busy), 0);
        step();
        chk("wdog_rdy_err2", 32'(err), 0);
`else
        // Without the watchdog a stalled transmitter keeps the arbiter busy
        req = 4'b0001;
        step();
        req = '0; bad = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (!(busy === 1'b1 && err === 1'b0)) bad++;
        end
        chk("stall_busy", 32'(bad), 0);
        tx_rdy = 1'b1;
        step();
        tx_rdy = 1'b0;
        chk("stall_release", 32'(busy), 0);
`endif

        // Randomized traffic following the requester protocol
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int n = 0; n < NREQ; n++) begin
                if (gnt[n]) req[n] = 1'b0;
                else if (req[n] && $urandom_range(31) == 0) req[n] = 1'b0;
                else if (!req[n] && $urandom_range(3) == 0) begin
                    req[n] = 1'b1;
                    data[n*8 +: 8] = 8'($urandom);
                end
            end
            if (busy && !tx_start) tx_rdy = ($urandom_range(3) == 0);
            else tx_rdy = ($urandom_range(7) == 0);
            if ($urandom_range(499) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/as_tx_arb.md
AS_TX_ARB -- requirements
Module: as_tx_arb

Interface
REQ-001 Parameters SHALL be, one per line:
  NREQ  4  number of requesters sharing one transmitter, 2..8
  WDOG_CYC  2000000  watchdog limit in clk_i cycles, used only when AS_TX_ARB_WDOG_EN is defined
REQ-002 The byte width SHALL be uart_width (8) from as_pack.
REQ-003 Ports SHALL be, one per line:
  clk_i  in  1  single clock, rising edge
  rst_ni  in  1  asynchronous active-low reset
  req_i  in  NREQ  per-requester transmit request, level
  data_i  in  NREQ*uart_width  per-requester byte; requester n uses bits [n*8+7:n*8]
  gnt_o  out  NREQ  one-hot, one-cycle pulse; byte of requester n accepted
  busy_o  out  1  high whenever state is not IDLE
  tx_start_o  out  1  one-cycle start pulse to the transmitter
  tx_data_o  out  uart_width  byte to the transmitter
  tx_rdy_i  in  1  one-cycle transmitter done pulse, issued after the stop bit
  err_o  out  1  one-cycle watchdog abort pulse

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, SEND, WAIT.
REQ-005 IDLE: if any req_i bit is high at a rising edge, the FSM SHALL select a winner and go to SEND; otherwise it SHALL stay in IDLE.
REQ-006 Winner selection SHALL be round-robin: the first requester with req_i high, searching from last+1 upward with wrap from NREQ-1 to 0.
REQ-007 In the SEND cycle, gnt_o[winner], tx_start_o and the registered tx_data_o = data_i[winner] SHALL all be valid together.
REQ-008 The latency SHALL be one cycle: req_i sampled at edge k gives gnt_o and tx_start_o high in cycle k+1.
REQ-009 On the SEND edge, last SHALL update to the winner, and the FSM SHALL go unconditionally to WAIT.
REQ-010 tx_data_o SHALL hold its value from SEND until the next SEND.
REQ-011 WAIT: on tx_rdy_i=1 the FSM SHALL return to IDLE; arbitration SHALL resume in the following IDLE cycle, giving a one-cycle gap.
REQ-012 tx_rdy_i SHALL be ignored in IDLE and SEND.
REQ-013 A requester SHALL hold req_i and data_i until it sees gnt_o; it SHALL deassert req_i in the cycle after gnt_o, or else it is served again.
REQ-014 A requester that drops req_i before its grant SHALL lose that request without any side effect.
REQ-015 Requests arriving during SEND or WAIT SHALL NOT be lost while held; they are arbitrated in the next IDLE.
REQ-016 gnt_o SHALL be one-hot or all-zero in every cycle.
REQ-017 tx_start_o SHALL never be high outside SEND.
REQ-018 With NREQ requesters all continuously requesting, each SHALL be granted exactly once per NREQ frames.

Reset
REQ-019 rst_ni low SHALL asynchronously force:
  - state to IDLE and last to NREQ-1, so requester 0 wins first;
  - gnt_o=0, busy_o=0, tx_start_o=0, tx_data_o=0, err_o=0;
  - the watchdog counter to 0.
REQ-020 Reset asserted in SEND or WAIT SHALL abandon the frame, with no gnt_o or err_o afterwards; the transmitter is reset by the same net.
REQ-021 The first arbitration after release SHALL occur at the first rising edge with rst_ni high.

Configuration
REQ-022 The macro AS_TX_ARB_WDOG_EN SHALL control the watchdog as follows:
  - Defined: a counter SHALL clear in SEND and increment each WAIT cycle. If it reaches WDOG_CYC without tx_rdy_i, the FSM SHALL go to IDLE and err_o SHALL pulse for one cycle on that transition.
  - Defined, with tx_rdy_i in the same cycle the limit is reached: tx_rdy_i wins and err_o stays 0.
  - Not defined: there is no counter, err_o SHALL be tied 0, and WAIT SHALL last until tx_rdy_i.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
  - Single request: req_i=4'b0100, data_i byte2=8'hA5 -> next cycle gnt_o=4'b0100, tx_start_o=1, tx_data_o=8'hA5; busy_o=1 until one cycle after tx_rdy_i.
  - Fairness: req_i=4'b1111 held, each grant acknowledged by rdy -> grant order 0,1,2,3,0 after reset.
  - Late request: req_i[3] rises mid-WAIT of requester 1 and req_i[2] is also high -> after rdy, requester 2 is granted first, then 3.
  - Withdrawal and reset: req_i[1] pulsed for one cycle during WAIT -> never granted. rst_ni low mid-WAIT -> all outputs 0 and, after release with req_i=4'b1000, gnt_o=4'b1000.
  - Watchdog (macro defined, WDOG_CYC=16): no tx_rdy_i -> err_o pulses once 16 WAIT cycles after SEND, then IDLE. Same test with rdy on cycle 16 -> no err_o.
  - Macro undefined: no tx_rdy_i for 10000 cycles -> busy_o stays 1 and err_o stays 0.
